// File: rtl/div_seq_pkg.sv
// Shared encodings and control constants for the multi-cycle divide sequencer.
package div_seq_pkg;

  localparam int DIV_DATA_W       = 32;
  localparam int DOUBLE_REG_BUS_W = 2 * DIV_DATA_W;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  function automatic logic [DIV_DATA_W-1:0] twos_neg(input logic [DIV_DATA_W-1:0] v);
    return ~v + 1'b1;
  endfunction

endpackage

// File: rtl/div_seq_step.sv
// One restoring-divide step: shift in the next dividend bit, trial-subtract,
// and produce the new partial remainder and the shifted-in quotient bit.
module div_seq_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);

  logic [DATA_W:0]   rem_sh;
  logic [DATA_W+1:0] diff;
  logic              borrow;

  // The shifted remainder can reach 2*divisor-1, so it needs one extra bit.
  always_comb begin
    rem_sh   = {rem, quo[DATA_W-1]};
    diff     = {1'b0, rem_sh} - {2'b00, divisor};
    borrow   = diff[DATA_W+1];
    rem_next = borrow ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
    quo_next = {quo[DATA_W-2:0], ~borrow};
  end

endmodule

// File: rtl/div_seq.sv
// Iterative signed/unsigned divide sequencer: one quotient bit per cycle,
// stalls the pipeline until {remainder, quotient} is ready for HI/LO.
//
// state       | meaning
// DIV_FREE    | idle, waiting for an accepted request
// DIV_BY_ZERO | divisor was zero, result forced to 0
// DIV_ON      | restoring loop running, one bit per cycle
// DIV_END     | result valid, held until start_i drops
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stall_req_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  div_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem_r;
  logic [DATA_W-1:0] quo_r;
  logic [DATA_W-1:0] divisor_r;
  logic              neg_quo_r;
  logic              neg_rem_r;

  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;
  logic [DATA_W-1:0] rem_fix;
  logic [DATA_W-1:0] quo_fix;
  logic              op1_neg;
  logic              op2_neg;
  logic [DATA_W-1:0] op1_mag;
  logic [DATA_W-1:0] op2_mag;

  div_seq_step #(.DATA_W(DATA_W)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (divisor_r),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );

  // Magnitudes are taken only for signed requests; -2^31 maps onto itself,
  // which is exactly the unsigned magnitude needed for the overflow case.
  always_comb begin
    op1_neg = signed_i & opdata1_i[DATA_W-1];
    op2_neg = signed_i & opdata2_i[DATA_W-1];
    op1_mag = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    op2_mag = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;
    quo_fix = neg_quo_r ? (~quo_nxt + 1'b1) : quo_nxt;
    rem_fix = neg_rem_r ? (~rem_nxt + 1'b1) : rem_nxt;
  end

  always_comb begin
    stall_req_o = 1'b0;
    case (state)
      DIV_FREE:    stall_req_o = (start_i == DIV_START) && !annul_i;
      DIV_BY_ZERO: stall_req_o = 1'b1;
      DIV_ON:      stall_req_o = 1'b1;
      default:     stall_req_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= DIV_FREE;
      cnt       <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      divisor_r <= '0;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      result_o  <= '0;
      ready_o   <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          if ((start_i == DIV_START) && !annul_i) begin
            rem_r     <= '0;
            quo_r     <= op1_mag;
            divisor_r <= op2_mag;
            neg_quo_r <= op1_neg ^ op2_neg;
            neg_rem_r <= op1_neg;
            cnt       <= '0;
            state     <= (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
          end
        end
        DIV_BY_ZERO: begin
          if (annul_i) begin
            state <= DIV_FREE;
          end else begin
            state    <= DIV_END;
            result_o <= '0;
            ready_o  <= DIV_RESULT_READY;
          end
        end
        DIV_ON: begin
          if (annul_i) begin
            state <= DIV_FREE;
            cnt   <= '0;
          end else begin
            rem_r <= rem_nxt;
            quo_r <= quo_nxt;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              state    <= DIV_END;
              result_o <= {rem_fix, quo_fix};
              ready_o  <= DIV_RESULT_READY;
            end
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            state    <= DIV_FREE;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results, divide by
// zero, annul and mid-operation reset.
module tb_div_seq;
  import div_seq_pkg::*;

  logic                        clk;
  logic                        rst_n;
  logic                        start_i;
  logic                        signed_i;
  logic [31:0]                 opdata1_i;
  logic [31:0]                 opdata2_i;
  logic                        annul_i;
  logic [DOUBLE_REG_BUS_W-1:0] result_o;
  logic                        ready_o;
  logic                        stall_req_o;

  int n_vec;
  int n_err;

  div_seq #(.DATA_W(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .stall_req_o (stall_req_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue a request with start held high; samples on falling edges, cycle 0
  // being the cycle before the accepting rising edge.
  task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input int exp_lat);
    int  cyc;
    bit  got;
    bit  stall_bad;
    @(negedge clk);
    start_i = 1'b1; signed_i = sg; opdata1_i = a; opdata2_i = b;
    #1;
    chk({tag, "_stall_c0"}, {63'd0, stall_req_o}, 64'd1);
    cyc = 0; got = 0; stall_bad = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ready_o) got = 1;
      else if (!stall_req_o) stall_bad = 1;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_stall_busy"}, {63'd0, stall_bad}, 64'd0);
    chk({tag, "_result"}, result_o, exp);
    chk({tag, "_stall_end"}, {63'd0, stall_req_o}, 64'd0);
    @(negedge clk);
    chk({tag, "_hold"}, {ready_o, result_o[62:0]}, {1'b1, exp[62:0]});
    start_i = 1'b0;
    @(negedge clk);
    chk({tag, "_clr"}, {63'd0, ready_o}, 64'd0);
    chk({tag, "_clr_res"}, result_o, 64'd0);
  endtask

  // Start a request, disturb it at cycle `at` with annul or reset, then make
  // sure nothing ever becomes ready for it.
  task automatic abort_div(input string tag, input bit use_rst, input int at);
    bit seen;
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    for (int i = 0; i < at; i++) @(negedge clk);
    start_i = 1'b0;
    if (use_rst) rst_n = 1'b0; else annul_i = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; annul_i = 1'b0;
    chk({tag, "_stall"}, {63'd0, stall_req_o}, 64'd0);
    chk({tag, "_ready"}, {63'd0, ready_o}, 64'd0);
    chk({tag, "_result"}, result_o, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o || stall_req_o) seen = 1;
    end
    chk({tag, "_quiet"}, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start_i = 1'b0; signed_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0; annul_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_result", result_o, 64'd0);
    chk("rst_stall", {63'd0, stall_req_o}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    annul_i = 1'b1; start_i = 1'b1;
    #1;
    chk("annul_idle_stall", {63'd0, stall_req_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    #1;
    chk("annul_idle_noaccept", {63'd0, stall_req_o}, 64'd0);

    run_div("u100_7",  1'b0, 32'd100,       32'd7,          {32'd2, 32'd14},              33);
    run_div("s_m7_2",  1'b1, 32'hFFFFFFF9,  32'h2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
    run_div("s_7_m2",  1'b1, 32'd7,         32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, 33);
    run_div("u_fff9_2",1'b0, 32'hFFFFFFF9,  32'h2,          {32'h00000001, 32'h7FFFFFFC}, 33);
    run_div("divzero", 1'b1, 32'h1234,      32'h0,          64'd0,                        2);
    abort_div("annul", 1'b0, 10);
    run_div("u9_3",    1'b0, 32'd9,         32'd3,          {32'd0, 32'd3},               33);
    abort_div("reset", 1'b1, 15);
    run_div("s_ovf",   1'b1, 32'h80000000,  32'hFFFFFFFF,   {32'h00000000, 32'h80000000}, 33);
    run_div("u_max_1", 1'b0, 32'hFFFFFFFF,  32'h1,          {32'h00000000, 32'hFFFFFFFF}, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for 32-bit signed/unsigned division, issued from the EX stage.
- Owns the iterative restoring divide loop: one quotient bit per cycle.
- Holds the pipeline via a stall request until the result is ready, then returns {remainder, quotient} to EX for HI/LO writeback.
- Sits beside ex; its stall request goes to the pipeline stall controller.

Parameters:
- DATA_W, 32, operand width; also the iteration count.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  clock, all state updates on the rising edge
- rst_n  input  1  reset; synchronous, active-low
- start_i  input  1  divide request from EX; held high until ready_o is seen
- signed_i  input  1  1 = signed divide (DIV), 0 = unsigned divide (DIVU); sampled with start_i
- opdata1_i  input  DATA_W  dividend; sampled when the request is accepted
- opdata2_i  input  DATA_W  divisor; sampled when the request is accepted
- annul_i  input  1  cancel the operation (flush or exception)
- result_o  output  2*DATA_W  {remainder, quotient}
- ready_o  output  1  result valid
- stall_req_o  output  1  request pipeline hold (combinational)

Behaviour:
- Reset (rst_n == 0 at a rising edge):
  - state = IDLE, counter = 0, internal registers = 0.
  - result_o = 0, ready_o = 0.
  - Reset takes priority over every other event, including reset mid-divide.
- States: IDLE, DIVZERO, ON, END. Encodings are shared constants.
- IDLE:
  - If start_i = 1 and annul_i = 0, the request is accepted and operands are latched.
  - Divisor == 0: next state DIVZERO.
  - Otherwise: next state ON, counter = 0.
  - For signed divides, latch the magnitudes of both operands and record the sign of each.
- DIVZERO:
  - Next state END, with result = 0 (quotient 0, remainder 0).
- ON:
  - Each cycle performs one restoring step: shift {partial remainder, dividend} left by 1; trial-subtract the divisor from the upper half; if there is no borrow, keep the difference and shift in quotient bit 1, else shift in 0.
  - counter increments each cycle.
  - When counter == DATA_W-1 the step completes and next state is END.
  - Final sign fix for signed divides:
    - Quotient is negated (two's complement) when the operand signs differ.
    - Remainder takes the sign of the dividend.
  - Register result_o = {remainder, quotient} on the transition into END.
- annul_i:
  - annul_i = 1 in ON or DIVZERO forces next state IDLE.
  - result_o and ready_o stay 0; the partial result is discarded.
  - annul_i = 1 in IDLE blocks acceptance of a request.
- END:
  - ready_o = 1 and result_o holds its value.
  - The state is held while start_i = 1.
  - When start_i = 0, next state is IDLE, result_o is cleared to 0 and ready_o is cleared to 0.
- stall_req_o (combinational):
  - 1 when (IDLE & start_i & !annul_i), or in DIVZERO, or in ON.
  - 0 in END and otherwise.
- Latency, with acceptance at edge 0:
  - Normal divide: ON occupies cycles 1..DATA_W; ready_o is high from cycle DATA_W+1 (33).
  - Divide by zero: ready_o is high from cycle 2.
- Overflow case: signed -2^31 / -1 gives quotient 0x80000000 and remainder 0 (wraps; no trap).
- A new request is accepted only in IDLE. start_i high throughout END does not re-trigger.

Decomposition:
- Shared macro/package additions:
  - State encodings: DivFree, DivByZero, DivOn, DivEnd.
  - Control values: DivStart, DivStop, DivResultReady, DivResultNotReady.
  - DoubleRegBus width macro.
- Optional sub-module div_step: combinational single restoring step (shift, trial subtract, quotient bit).
- The FSM, counter and sign handling stay in div_seq.

Test Plan:
- Unsigned 100 / 7, start held high → stall_req_o high cycles 0..32; ready_o high at cycle 33; result_o = {32'd2, 32'd14}; drop start_i → ready_o 0 and result_o 0 next cycle.
- Signed -7 / 2 (0xFFFFFFF9, 0x2) → result_o = {0xFFFFFFFF, 0xFFFFFFFD}; signed 7 / -2 → {0x00000001, 0xFFFFFFFD}.
- Divisor 0 (opdata1_i = 0x1234) → ready_o at cycle 2, result_o = 0, stall_req_o low from cycle 2.
- annul_i pulsed at cycle 10 of ON → IDLE next cycle; ready_o never asserts; a new 9 / 3 request afterwards returns {0, 3}.
- rst_n low for one edge mid-ON (cycle 15) → all outputs 0; state IDLE; no ready_o for the aborted op.
- Signed 0x80000000 / 0xFFFFFFFF → result_o = {0x00000000, 0x80000000}; unsigned 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
